// File: rtl/qnigma_mdio_target.sv
// qnigma_mdio_target: Clause 22 MDIO management target (PHY side of MDC/MDIO).
// Oversamples MDC/MDIO on clk, decodes preamble/ST/OP/PHYAD/REGAD/TA/DATA and
// turns writes into a one-cycle write strobe; reads are served from a register
// read port and shifted out through the MDIO tristate.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   mdc, mdi          management clock and MDIO line input (asynchronous)
//   mdo, mdt          MDIO output value and tristate control (1 = released)
//   rd_stb, rd_adr    one-cycle read request and its register address
//   rd_dat            read data, held from rd_stb until the next MDC rising edge
//   wr_val, wr_adr,
//   wr_dat            one-cycle write strobe, address and data (held until next write)
//   frm_err           one-cycle pulse on a malformed frame addressed to PHY_ADDR
//
// Optional feature macro: QNIGMA_MDIO_PREAMBLE_SUPPRESS_EN
//   When defined, after the first completed or skipped frame a start-of-frame is
//   accepted without a preamble. Undefined: every frame needs PREAMBLE_LEN ones.

module qnigma_mdio_target #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int unsigned PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdi,
  output logic        mdo,
  output logic        mdt,
  output logic        rd_stb,
  output logic [4:0]  rd_adr,
  input  logic [15:0] rd_dat,
  output logic        wr_val,
  output logic [4:0]  wr_adr,
  output logic [15:0] wr_dat,
  output logic        frm_err
);

  localparam int unsigned PW = $clog2(PREAMBLE_LEN + 1);
  localparam int unsigned CW = 5;

  // Post-ST cell indices: OP = 0..1, PHYAD = 2..6, REGAD = 7..11, TA = 12..13, DATA = 14..29
  localparam logic [CW-1:0] IDX_OP1 = CW'(1);
  localparam logic [CW-1:0] IDX_PHY = CW'(6);
  localparam logic [CW-1:0] IDX_REG = CW'(11);
  localparam logic [CW-1:0] IDX_TA1 = CW'(12);
  localparam logic [CW-1:0] IDX_D0  = CW'(29);

  typedef enum logic [3:0] {
    S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA, S_SKIP
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      mdc_sync_q, mdc_sync_d;
  logic [1:0]      mdi_sync_q, mdi_sync_d;
  logic [PW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [14:0]     sh_q, sh_d;
  logic [15:0]     tx_q, tx_d;
  logic            rd_op_q, rd_op_d;
  logic            err_q, err_d;
  logic            match_q, match_d;
  logic [4:0]      regad_q, regad_d;
  logic            mdo_q, mdo_d;
  logic            mdt_q, mdt_d;
  logic            rd_stb_q, rd_stb_d;
  logic [4:0]      rd_adr_q, rd_adr_d;
  logic            wr_val_q, wr_val_d;
  logic [4:0]      wr_adr_q, wr_adr_d;
  logic [15:0]     wr_dat_q, wr_dat_d;
  logic            frm_err_q, frm_err_d;

  logic            edge_c;
  logic            bit_c;
  logic            done_c;
  logic            sup_c;

  // Two-stage synchronizers; the third mdc stage is the previous synced value for edge detection
  always_comb begin
    mdc_sync_d = {mdc_sync_q[1:0], mdc};
    mdi_sync_d = {mdi_sync_q[0], mdi};
  end

  assign edge_c = mdc_sync_q[1] & ~mdc_sync_q[2];
  assign bit_c  = mdi_sync_q[1];

`ifdef QNIGMA_MDIO_PREAMBLE_SUPPRESS_EN
  // Set once any frame has run to completion; only reset clears it
  logic sup_q, sup_d;

  assign sup_d = sup_q | done_c;
  assign sup_c = sup_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sup_q <= 1'b0;
    else     sup_q <= sup_d;
  end
`else
  assign sup_c = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mdc_sync_q <= '0;
      mdi_sync_q <= '1;
      pre_cnt_q  <= '0;
      cnt_q      <= '0;
      sh_q       <= '0;
      tx_q       <= '0;
      rd_op_q    <= 1'b0;
      err_q      <= 1'b0;
      match_q    <= 1'b0;
      regad_q    <= '0;
      mdo_q      <= 1'b1;
      mdt_q      <= 1'b1;
      rd_stb_q   <= 1'b0;
      rd_adr_q   <= '0;
      wr_val_q   <= 1'b0;
      wr_adr_q   <= '0;
      wr_dat_q   <= '0;
      frm_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mdc_sync_q <= mdc_sync_d;
      mdi_sync_q <= mdi_sync_d;
      pre_cnt_q  <= pre_cnt_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      rd_op_q    <= rd_op_d;
      err_q      <= err_d;
      match_q    <= match_d;
      regad_q    <= regad_d;
      mdo_q      <= mdo_d;
      mdt_q      <= mdt_d;
      rd_stb_q   <= rd_stb_d;
      rd_adr_q   <= rd_adr_d;
      wr_val_q   <= wr_val_d;
      wr_adr_q   <= wr_adr_d;
      wr_dat_q   <= wr_dat_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // Frame decoder: everything advances only on a synced MDC rising edge
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    rd_op_d   = rd_op_q;
    err_d     = err_q;
    match_d   = match_q;
    regad_d   = regad_q;
    mdo_d     = mdo_q;
    mdt_d     = mdt_q;
    rd_stb_d  = 1'b0;
    rd_adr_d  = rd_adr_q;
    wr_val_d  = 1'b0;
    wr_adr_d  = wr_adr_q;
    wr_dat_d  = wr_dat_q;
    frm_err_d = 1'b0;
    done_c    = 1'b0;

    if (edge_c) begin
      // Post-ST cells are shifted and counted uniformly; PHYAD match is captured
      // even while skipping so a bad-OP frame can still report frm_err
      if (state_q != S_IDLE && state_q != S_ST2) begin
        sh_d  = {sh_q[13:0], bit_c};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == IDX_PHY) match_d = ({sh_q[3:0], bit_c} == PHY_ADDR);
      end

      case (state_q)
        S_IDLE: begin
          if (bit_c) begin
            if (pre_cnt_q != PW'(PREAMBLE_LEN)) pre_cnt_d = pre_cnt_q + PW'(1);
          end else if (pre_cnt_q == PW'(PREAMBLE_LEN) || sup_c) begin
            state_d = S_ST2;
          end else begin
            pre_cnt_d = '0;
          end
        end
        S_ST2: begin
          pre_cnt_d = '0;
          if (bit_c) begin
            state_d = S_OP;
            cnt_d   = '0;
            err_d   = 1'b0;
            match_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_OP: begin
          if (cnt_q == IDX_OP1) begin
            case ({sh_q[0], bit_c})
              2'b10:   begin rd_op_d = 1'b1; state_d = S_PHYAD; end
              2'b01:   begin rd_op_d = 1'b0; state_d = S_PHYAD; end
              default: begin err_d = 1'b1;   state_d = S_SKIP;  end
            endcase
          end
        end
        S_PHYAD: begin
          if (cnt_q == IDX_PHY)
            state_d = ({sh_q[3:0], bit_c} == PHY_ADDR) ? S_REGAD : S_SKIP;
        end
        S_REGAD: begin
          if (cnt_q == IDX_REG) begin
            regad_d = {sh_q[3:0], bit_c};
            state_d = S_TA;
            if (rd_op_q) begin
              rd_stb_d = 1'b1;
              rd_adr_d = {sh_q[3:0], bit_c};
            end
          end
        end
        S_TA: begin
          if (rd_op_q) begin
            // Take the bus for TA cell 2 (driven low) and capture read data
            mdt_d   = 1'b0;
            mdo_d   = 1'b0;
            tx_d    = rd_dat;
            state_d = S_RDATA;
          end else if (cnt_q == IDX_TA1) begin
            if (!bit_c) err_d = 1'b1;
          end else begin
            if (bit_c) err_d = 1'b1;
            state_d = S_WDATA;
          end
        end
        S_RDATA: begin
          if (cnt_q == IDX_D0) begin
            mdt_d  = 1'b1;
            mdo_d  = 1'b1;
            done_c = 1'b1;
          end else begin
            mdo_d = tx_q[15];
            tx_d  = {tx_q[14:0], 1'b0};
          end
        end
        S_WDATA: begin
          if (cnt_q == IDX_D0) begin
            done_c = 1'b1;
            if (err_q) begin
              frm_err_d = 1'b1;
            end else begin
              wr_val_d = 1'b1;
              wr_adr_d = regad_q;
              wr_dat_d = {sh_q, bit_c};
            end
          end
        end
        S_SKIP: begin
          if (cnt_q == IDX_D0) begin
            done_c    = 1'b1;
            frm_err_d = err_q & match_q;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (done_c) begin
        state_d   = S_IDLE;
        pre_cnt_d = '0;
      end
    end
  end

  assign mdo     = mdo_q;
  assign mdt     = mdt_q;
  assign rd_stb  = rd_stb_q;
  assign rd_adr  = rd_adr_q;
  assign wr_val  = wr_val_q;
  assign wr_adr  = wr_adr_q;
  assign wr_dat  = wr_dat_q;
  assign frm_err = frm_err_q;

endmodule
